// File: rtl/pipelined_addsub_pkg.sv
// ============================================================================
// Module   : pipelined_addsub_pkg
// Brief    : Operation encodings and operand-conditioning helpers shared by
//            the segmented add/sub pipeline and its clients.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipelined_addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBB = 2'b11
    } op_e;

    // Subtracting forms add the one's complement of B.
    function automatic logic op_invert_b(input op_e op);
        return (op == OP_SUB) || (op == OP_SBB);
    endfunction

    function automatic logic op_carry_in(input op_e op, input logic c_in);
        logic w_c;
        case (op)
            OP_ADD:  w_c = 1'b0;
            OP_SUB:  w_c = 1'b1;
            default: w_c = c_in;
        endcase
        return w_c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipelined_addsub_seg_adder.sv
// ============================================================================
// Module   : pipelined_addsub_seg_adder
// Brief    : Combinational W-bit ripple adder slice with carry in and out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_addsub_seg_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_c,
    output logic [W-1:0] o_sum,
    output logic         o_c
);

    logic [W:0] w_total;

    assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_c};
    assign o_sum   = w_total[W-1:0];
    assign o_c     = w_total[W];

endmodule

`default_nettype wire

// File: rtl/pipelined_addsub.sv
// ============================================================================
// Module   : pipelined_addsub
// Brief    : Segmented-carry pipelined adder/subtractor (ADD/SUB/ADC/SBB)
//            with valid/ready on both sides and carry/overflow/zero flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int bNUM = 32,
    parameter int SEG  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [bNUM-1:0] A,
    input  logic [bNUM-1:0] B,
    input  logic [1:0]      op,
    input  logic            C_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [bNUM-1:0] Sum,
    output logic            C_out,
    output logic            ovf,
    output logic            zero
);

    localparam int c_SEG_W = bNUM / SEG;
    localparam int c_NSKEW = (SEG > 1) ? SEG - 1 : 1;

    logic            w_adv;
    logic [bNUM-1:0] w_bx;
    logic            w_c0;
    logic            w_ovf;

    // Per-stage inputs and results; stage k works on segment k.
    logic [bNUM-1:0] w_a_in   [SEG];
    logic [bNUM-1:0] w_bx_in  [SEG];
    logic [bNUM-1:0] w_sum_in [SEG];
    logic [bNUM-1:0] w_sum_out[SEG];
    logic            w_c_in   [SEG];
    logic            w_c_out  [SEG];
    logic            w_v_in   [SEG];

    // Inter-stage registers: skewed operands, deskewed partial sums, carry, valid.
    logic [bNUM-1:0] r_a  [c_NSKEW];
    logic [bNUM-1:0] r_bx [c_NSKEW];
    logic [bNUM-1:0] r_sum[c_NSKEW];
    logic            r_c  [c_NSKEW];
    logic            r_v  [c_NSKEW];

    logic [bNUM-1:0] r_out_sum;
    logic            r_out_c;
    logic            r_out_ovf;
    logic            r_out_v;

    assign w_adv = !r_out_v || out_ready;
    assign w_bx  = op_invert_b(op_e'(op)) ? ~B : B;
    assign w_c0  = op_carry_in(op_e'(op), C_in);

    for (genvar k = 0; k < SEG; k++) begin : g_stage
        logic [c_SEG_W-1:0] w_seg_sum;
        logic [bNUM-1:0]    w_merged;

        if (k == 0) begin : g_head
            assign w_a_in[k]   = A;
            assign w_bx_in[k]  = w_bx;
            assign w_sum_in[k] = '0;
            assign w_c_in[k]   = w_c0;
            assign w_v_in[k]   = in_valid;
        end else begin : g_link
            assign w_a_in[k]   = r_a[k-1];
            assign w_bx_in[k]  = r_bx[k-1];
            assign w_sum_in[k] = r_sum[k-1];
            assign w_c_in[k]   = r_c[k-1];
            assign w_v_in[k]   = r_v[k-1];
        end

        pipelined_addsub_seg_adder #(
            .W(c_SEG_W)
        ) u_seg (
            .i_a  (w_a_in[k][k*c_SEG_W +: c_SEG_W]),
            .i_b  (w_bx_in[k][k*c_SEG_W +: c_SEG_W]),
            .i_c  (w_c_in[k]),
            .o_sum(w_seg_sum),
            .o_c  (w_c_out[k])
        );

        always_comb begin
            w_merged = w_sum_in[k];
            w_merged[k*c_SEG_W +: c_SEG_W] = w_seg_sum;
        end

        assign w_sum_out[k] = w_merged;
    end

    // Overflow uses the operand sign bits still carried by the last stage.
    assign w_ovf = (w_a_in[SEG-1][bNUM-1] == w_bx_in[SEG-1][bNUM-1])
                && (w_sum_out[SEG-1][bNUM-1] != w_a_in[SEG-1][bNUM-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < c_NSKEW; j++) begin
                r_a[j]   <= '0;
                r_bx[j]  <= '0;
                r_sum[j] <= '0;
                r_c[j]   <= 1'b0;
                r_v[j]   <= 1'b0;
            end
            r_out_sum <= '0;
            r_out_c   <= 1'b0;
            r_out_ovf <= 1'b0;
            r_out_v   <= 1'b0;
        end else if (w_adv) begin
            for (int j = 0; j < SEG - 1; j++) begin
                r_a[j]   <= w_a_in[j];
                r_bx[j]  <= w_bx_in[j];
                r_sum[j] <= w_sum_out[j];
                r_c[j]   <= w_c_out[j];
                r_v[j]   <= w_v_in[j];
            end
            r_out_sum <= w_sum_out[SEG-1];
            r_out_c   <= w_c_out[SEG-1];
            r_out_ovf <= w_ovf;
            r_out_v   <= w_v_in[SEG-1];
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_out_v;
    assign Sum       = r_out_sum;
    assign C_out     = r_out_c;
    assign ovf       = r_out_ovf;
    assign zero      = (r_out_sum == '0);

endmodule

`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
// ============================================================================
// Module   : tb_pipelined_addsub
// Brief    : Directed self-checking bench for the pipelined adder/subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_addsub;

    localparam int c_W   = 32;
    localparam int c_SEG = 4;

    localparam logic [1:0] c_ADD = 2'b00;
    localparam logic [1:0] c_SUB = 2'b01;
    localparam logic [1:0] c_ADC = 2'b10;
    localparam logic [1:0] c_SBB = 2'b11;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [c_W-1:0] A;
    logic [c_W-1:0] B;
    logic [1:0]     op;
    logic           C_in;
    logic           out_valid;
    logic           out_ready;
    logic [c_W-1:0] Sum;
    logic           C_out;
    logic           ovf;
    logic           zero;

    int n_chk  = 0;
    int n_pass = 0;

    pipelined_addsub #(
        .bNUM(c_W),
        .SEG (c_SEG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .op       (op),
        .C_in     (C_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Sum      (Sum),
        .C_out    (C_out),
        .ovf      (ovf),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // One isolated beat: drive, wait for the result, check latency and flags.
    task automatic run_one(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic ci, input logic [31:0] e_sum,
                           input logic e_c, input logic e_ovf, output logic c_seen);
        int lat;
        in_valid = 1'b1; op = o; A = a; B = b; C_in = ci;
        #1;
        chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, c_SEG - 1);
        chk({tag, " Sum"},   Sum, e_sum);
        chk({tag, " C_out"}, {31'd0, C_out}, {31'd0, e_c});
        chk({tag, " ovf"},   {31'd0, ovf},   {31'd0, e_ovf});
        chk({tag, " zero"},  {31'd0, zero},  {31'd0, e_sum == 32'd0});
        c_seen = C_out;
    endtask

    // Back-to-back stream vectors.
    logic [1:0]  s_op  [8] = '{c_ADD, c_SUB, c_ADC, c_SBB, c_ADD, c_SUB, c_ADC, c_SBB};
    logic [31:0] s_a   [8] = '{32'h12345678, 32'h00000010, 32'h7FFFFFFF, 32'h00000000,
                               32'h80000000, 32'h00000003, 32'h0000FFFF, 32'h00000100};
    logic [31:0] s_b   [8] = '{32'h11111111, 32'h00000010, 32'h00000000, 32'h00000000,
                               32'h80000000, 32'h00000001, 32'h00000001, 32'h00000001};
    logic        s_ci  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] s_sum [8] = '{32'h23456789, 32'h00000000, 32'h80000000, 32'hFFFFFFFF,
                               32'h00000000, 32'h00000002, 32'h00010000, 32'h000000FF};
    logic        s_c   [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        s_ovf [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Stall-test vectors (all ADD).
    logic [31:0] f_a   [6] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
    logic [31:0] f_b   [6] = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60};
    logic [31:0] f_sum [6] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic c_lo;
        logic c_dummy;
        logic acc;
        logic con;
        logic [31:0] obs;
        int tx;
        int rx;
        int extra;

        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; op = c_ADD; C_in = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #3;
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst Sum",       Sum, 32'd0);
        chk("rst C_out",     {31'd0, C_out}, 32'd0);
        chk("rst ovf",       {31'd0, ovf}, 32'd0);
        chk("rst zero",      {31'd0, zero}, 32'd1);
        chk("rst in_ready",  {31'd0, in_ready}, 32'd1);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-beat directed cases
        run_one("add_wrap", c_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, c_dummy);
        run_one("sub_ovf",  c_SUB, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, c_dummy);
        run_one("sub_neg",  c_SUB, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, c_dummy);

        // Back-to-back stream: first result after 3 more edges, then one per cycle
        for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
                in_valid = 1'b1; op = s_op[c]; A = s_a[c]; B = s_b[c]; C_in = s_ci[c];
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (c >= 3) begin
                chk($sformatf("stream%0d valid", c - 3), {31'd0, out_valid}, 32'd1);
                chk($sformatf("stream%0d Sum", c - 3), Sum, s_sum[c-3]);
                chk($sformatf("stream%0d C_out", c - 3), {31'd0, C_out}, {31'd0, s_c[c-3]});
                chk($sformatf("stream%0d ovf", c - 3), {31'd0, ovf}, {31'd0, s_ovf[c-3]});
            end else begin
                chk($sformatf("stream fill%0d valid", c), {31'd0, out_valid}, 32'd0);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Fill, stall three cycles, then drain
        tx = 0; rx = 0;
        for (int c = 0; c < 40 && rx < 6; c++) begin
            out_ready = (c >= 7);
            if (tx < 6) begin
                in_valid = 1'b1; op = c_ADD; A = f_a[tx]; B = f_b[tx]; C_in = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c >= 4 && c <= 6) begin
                chk($sformatf("stall%0d in_ready", c), {31'd0, in_ready}, 32'd0);
                chk($sformatf("stall%0d out_valid", c), {31'd0, out_valid}, 32'd1);
                chk($sformatf("stall%0d Sum frozen", c), Sum, f_sum[0]);
            end
            acc = in_valid && in_ready;
            con = out_valid && out_ready;
            obs = Sum;
            if (con) begin
                chk($sformatf("drain%0d Sum", rx), obs, f_sum[rx]);
                rx++;
            end
            @(posedge clk); #1;
            if (acc) tx++;
        end
        chk("drain count", rx, 6);
        chk("accept count", tx, 6);
        in_valid = 1'b0;
        out_ready = 1'b1;
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        chk("no duplicate", extra, 0);

        // 64-bit chained add and subtract
        run_one("add64 lo", c_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, c_lo);
        run_one("adc64 hi", c_ADC, 32'h00000001, 32'h00000002, c_lo, 32'h00000004, 1'b0, 1'b0, c_dummy);
        run_one("sub64 lo", c_SUB, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, c_lo);
        run_one("sbb64 hi", c_SBB, 32'h00000001, 32'h00000000, c_lo, 32'h00000000, 1'b1, 1'b0, c_dummy);

        // Asynchronous reset with beats in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; op = c_ADD; A = 32'h100 * (i + 1); B = 32'h7; C_in = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("async rst Sum",       Sum, 32'd0);
        chk("async rst zero",      {31'd0, zero}, 32'd1);
        chk("async rst in_ready",  {31'd0, in_ready}, 32'd1);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        chk("no stale after reset", extra, 0);
        run_one("post-reset add", c_ADD, 32'h00000002, 32'h00000003, 1'b0, 32'h00000005, 1'b0, 1'b0, c_dummy);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, segmented-carry pipelined adder/subtractor with valid/ready handshakes on both sides. Operands are split into SEG equal segments. Each pipeline stage adds one segment and registers the carry into the next stage, so the clock period is set by a bNUM/SEG-bit ripple rather than a full-width ripple. It serves as the multi-mode arithmetic core for the EX stage and for the multi-word arithmetic datapath. It supports add, subtract, add-with-carry and subtract-with-borrow, and produces carry, signed-overflow and zero flags.

## Interface
Parameters:
- bNUM, 32, operand and result width; bNUM % SEG must be 0.
- SEG, 4, number of segments, which is also the pipeline depth; SEG ≥ 1.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand beat present.
- in_ready  output  1  pipeline can accept a beat this cycle.
- A  input  bNUM  operand A.
- B  input  bNUM  operand B.
- op  input  2  operation: 00 ADD, 01 SUB, 10 ADC, 11 SBB.
- C_in  input  1  carry/not-borrow input; used only by ADC and SBB.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- Sum  output  bNUM  result.
- C_out  output  1  carry out; for SUB/SBB, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  Sum == 0.

## Operation
- Effective operand: Bx = B for ADD/ADC, Bx = ~B for SUB/SBB.
- Initial carry c0: ADD 0, SUB 1, ADC C_in, SBB C_in.
- Stage k (0..SEG-1) computes segment k as A_k + Bx_k + c_k, where c_k is the registered carry-out of stage k-1.
- Upper, not-yet-used segments of A and Bx are carried forward in skew registers.
- Completed lower Sum segments are carried forward in deskew registers, so all Sum bits emerge aligned.
- Result = (A + Bx + c0) mod 2^bNUM.
- C_out = carry out of bit bNUM-1.
- ovf = (A[bNUM-1] == Bx[bNUM-1]) && (Sum[bNUM-1] != A[bNUM-1]).
- zero is computed combinationally from the final Sum register.
- Each stage holds a valid bit. Bubbles propagate and do not cause stalls.
- Global advance: adv = !out_valid || out_ready. in_ready = adv.
  - adv = 1: every stage shifts forward one position; stage 0 loads {in_valid, operands}.
  - adv = 0: every register holds its value.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - Sum, C_out, ovf and zero stay stable while out_valid && !out_ready.
- Ordering is strict FIFO. There is no loss and no duplication.
- Simultaneous accept and consume when full: allowed; throughput is one beat per cycle.
- in_valid with adv = 0: the beat is not taken; the upstream must hold it.
- Reset: all valid bits 0, all data registers 0. While rst_n is low: out_valid 0, Sum 0, C_out 0, ovf 0, zero 1, in_ready 1. Reset asserted mid-operation discards every in-flight beat immediately; nothing from before reset is emitted after release.

## Timing
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t+SEG-1. When SEG = 1, the result is registered with latency 1.
- Throughput: 1 beat per cycle while out_ready = 1.
- Critical path: a bNUM/SEG-bit ripple plus the flag logic on the last stage.
- in_ready depends combinationally on out_ready; out_valid and Sum are registered.

## Structure
- Shared header alu_defs.vh holds the op encodings OP_ADD, OP_SUB, OP_ADC and OP_SBB, used by the decoder and the EX stage.
- Sub-module seg_adder (#(W)): a combinational W-bit adder with carry in and out. It is instantiated SEG times through generate.
- Skew, deskew and valid registers live in pipelined_addsub.

## Test plan
1. ADD, A = 0xFFFFFFFF, B = 0x00000001, out_ready = 1 → 4 cycles later: Sum = 0x00000000, C_out = 1, ovf = 0, zero = 1.
2. SUB, A = 0x80000000, B = 0x00000001 → Sum = 0x7FFFFFFF, C_out = 1, ovf = 1, zero = 0. Also SUB 5 − 7 → Sum = 0xFFFFFFFE, C_out = 0, ovf = 0.
3. Stream of 8 back-to-back random beats covering all ops, out_ready = 1 → first result at cycle 4, then one result per cycle, in order, all matching the reference model.
4. Pipeline full with out_ready held low for 3 cycles → in_ready = 0 and outputs frozen during the stall; after release, all beats emerge with none lost or duplicated.
5. 64-bit chain: ADD on the low words (0xFFFFFFFF + 1), then ADC on the high words (0x00000001 + 0x00000002) with C_in = the previous C_out → high Sum = 0x00000004. Repeat with SUB/SBB on 0x1_00000000 − 1 → low 0xFFFFFFFF, high 0x00000000.
6. rst_n pulsed low with 3 beats in flight → out_valid drops to 0 asynchronously; after release, no stale result appears, and a new ADD 2 + 3 returns Sum = 5.
